// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port
// indices and the default burst limit.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int PORT_CPU      = 0;
  localparam int PORT_LDR      = 1;
  localparam int MAX_BURST_DEF = 4;

  // Bits needed to hold a count of 0..max inclusive.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arb_reg.sv
// Counter register with clear and increment; cl together with inc loads 1,
// so a fresh burst can be opened in a single cycle.
module mem_arb_reg #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         cl,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (cl) begin
      q_d = inc ? W'(1) : '0;
    end else if (inc) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU / loader) single-memory arbiter with round-robin priority
// and bounded lock bursts; read data returns one cycle after the grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = MAX_BURST_DEF,
  localparam int BW        = cnt_width(MAX_BURST)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output arb_state_e            dbg_state,
  output logic                  dbg_prio,
  output logic [BW-1:0]         dbg_bcnt
);

  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

  // Handshake: a port holds req/we/addr/wdata until it sees gnt in the same
  // cycle; the access is taken at the rising edge that ends that cycle.

  arb_state_e    state_q, state_d;
  logic          prio_q, prio_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_port_q, rd_port_d;
  logic [BW-1:0] bcnt_q;
  logic          bcnt_inc, bcnt_cl;
  logic          own0, own1;
  logic          g0, g1;

  mem_arb_reg #(.W(BW)) u_bcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bcnt_inc),
    .cl    (bcnt_cl),
    .q     (bcnt_q)
  );

  assign own0 = (state_q == OWN0) && req0 && lock0;
  assign own1 = (state_q == OWN1) && req1 && lock1;

  always_comb begin
    g0       = 1'b0;
    g1       = 1'b0;
    state_d  = state_q;
    prio_d   = prio_q;
    bcnt_inc = 1'b0;
    bcnt_cl  = 1'b0;

    if (own0) begin
      if (req1 && bcnt_q == MAX_B) g1 = 1'b1;
      else                         g0 = 1'b1;
    end else if (own1) begin
      if (req0 && bcnt_q == MAX_B) g0 = 1'b1;
      else                         g1 = 1'b1;
    end else if (req0 && req1) begin
      if (prio_q) g1 = 1'b1;
      else        g0 = 1'b1;
    end else if (req0) begin
      g0 = 1'b1;
    end else if (req1) begin
      g1 = 1'b1;
    end

    // A continuing owner extends its burst; any other grant opens a new one.
    if ((own0 && g0) || (own1 && g1)) begin
      bcnt_inc = (bcnt_q < MAX_B);
      prio_d   = g0;
    end else if (g0) begin
      prio_d   = 1'b1;
      bcnt_cl  = 1'b1;
      bcnt_inc = lock0;
      state_d  = lock0 ? OWN0 : IDLE;
    end else if (g1) begin
      prio_d   = 1'b0;
      bcnt_cl  = 1'b1;
      bcnt_inc = lock1;
      state_d  = lock1 ? OWN1 : IDLE;
    end else begin
      bcnt_cl  = 1'b1;
      state_d  = IDLE;
    end
  end

  assign rd_pend_d = (g0 && !we0) || (g1 && !we1);
  assign rd_port_d = g1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  assign gnt0     = g0;
  assign gnt1     = g1;
  assign mem_we   = g0 ? we0    : (g1 ? we1    : 1'b0);
  assign mem_addr = g0 ? addr0  : (g1 ? addr1  : '0);
  assign mem_data = g0 ? wdata0 : (g1 ? wdata1 : '0);

  assign rvalid0 = rd_pend_q && (rd_port_q == 1'b0);
  assign rvalid1 = rd_pend_q && (rd_port_q == 1'b1);
  assign rdata0  = rvalid0 ? mem_in : '0;
  assign rdata1  = rvalid1 ? mem_in : '0;

  assign dbg_state = state_q;
  assign dbg_prio  = prio_q;
  assign dbg_bcnt  = bcnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a registered-read
// memory model and an expected-read queue.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int MB = 4;
  localparam int BW = cnt_width(MB);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_data;
  logic [DW-1:0] mem_in = '0;
  logic [AW-1:0] mem_addr;
  arb_state_e    dbg_state;
  logic          dbg_prio;
  logic [BW-1:0] dbg_bcnt;

  logic [DW-1:0] mem [64];
  logic [DW:0]   exp_q[$];

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_in(mem_in),
    .dbg_state(dbg_state), .dbg_prio(dbg_prio), .dbg_bcnt(dbg_bcnt)
  );

  // Clock and memory model: data read appears one cycle after its address.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_in <= mem[mem_addr];
  end

  task automatic drive_idle();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (dbg_state !== IDLE) begin fails++; $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE); end
    tests++; if (dbg_prio !== 1'b0) begin fails++; $display("FAIL reset_prio got %0b exp 0", dbg_prio); end
    tests++; if (dbg_bcnt !== '0) begin fails++; $display("FAIL reset_bcnt got %0d exp 0", dbg_bcnt); end
    tests++; if ({gnt0, gnt1} !== 2'b00) begin fails++; $display("FAIL reset_gnt got %b exp 00", {gnt0, gnt1}); end
    tests++; if ({rvalid0, rvalid1} !== 2'b00) begin fails++; $display("FAIL reset_rvalid got %b exp 00", {rvalid0, rvalid1}); end
    tests++; if (rdata0 !== '0 || rdata1 !== '0) begin fails++; $display("FAIL reset_rdata got %h/%h exp 0/0", rdata0, rdata1); end
    tests++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_data !== '0) begin fails++; $display("FAIL reset_mem got we=%b a=%h d=%h exp 0", mem_we, mem_addr, mem_data); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 6'd8;
    @(negedge clk);
    tests++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin fails++; $display("FAIL read_gnt got %b%b exp 10", gnt0, gnt1); end
    tests++; if (mem_addr !== 6'd8 || mem_we !== 1'b0) begin fails++; $display("FAIL read_addr got a=%0d we=%b exp 8/0", mem_addr, mem_we); end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    tests++; if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0) begin fails++; $display("FAIL read_rvalid got %b%b exp 10", rvalid0, rvalid1); end
    tests++; if (rdata0 !== 16'h1234) begin fails++; $display("FAIL read_rdata got %h exp 1234", rdata0); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (rvalid0 !== 1'b0 || rdata0 !== '0) begin fails++; $display("FAIL read_one_shot got v=%b d=%h exp 0/0", rvalid0, rdata0); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    do_reset();
    @(posedge clk); #1;
    req0 = 1; addr0 = 6'd1; req1 = 1; addr1 = 6'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      tests++; if ({gnt0, gnt1} !== exp_g) begin fails++; $display("FAIL alt_gnt cyc %0d got %b exp %b", i, {gnt0, gnt1}, exp_g); end
      if (i > 0) begin
        tests++; if ({rvalid0, rvalid1} !== ~exp_g) begin fails++; $display("FAIL alt_tag cyc %0d got %b exp %b", i, {rvalid0, rvalid1}, ~exp_g); end
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  task automatic test_lock_burst();
    logic [1:0] exp_g;
    do_reset();
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 6'd3; wdata0 = 16'h0003;
    @(posedge clk); #1;
    tests++; if (dbg_prio !== 1'b1) begin fails++; $display("FAIL burst_prio got %b exp 1", dbg_prio); end
    we0 = 0; req1 = 1; lock1 = 1; addr1 = 6'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_g = (i < 4) ? 2'b01 : 2'b10;
      tests++; if ({gnt0, gnt1} !== exp_g) begin fails++; $display("FAIL burst_gnt cyc %0d got %b exp %b", i, {gnt0, gnt1}, exp_g); end
      if (i > 0 && i < 4) begin
        tests++; if (dbg_bcnt !== BW'(i)) begin fails++; $display("FAIL burst_bcnt cyc %0d got %0d exp %0d", i, dbg_bcnt, i); end
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 6'd63; wdata0 = 16'hBEEF;
    @(negedge clk);
    tests++; if (gnt0 !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd63 || mem_data !== 16'hBEEF) begin
      fails++; $display("FAIL raw_write got g=%b we=%b a=%0d d=%h exp 1/1/63/BEEF", gnt0, mem_we, mem_addr, mem_data);
    end
    @(posedge clk); #1;
    drive_idle();
    req1 = 1; addr1 = 6'd63;
    @(negedge clk);
    tests++; if (gnt1 !== 1'b1 || rvalid0 !== 1'b0) begin fails++; $display("FAIL raw_rgnt got g1=%b rv0=%b exp 1/0", gnt1, rvalid0); end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    tests++; if (rvalid1 !== 1'b1 || rdata1 !== 16'hBEEF) begin fails++; $display("FAIL raw_rdata got v=%b d=%h exp 1/BEEF", rvalid1, rdata1); end
    tests++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL raw_rv0 got %b exp 0", rvalid0); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    @(posedge clk); #1;
    req1 = 1; addr1 = 6'd5;
    @(posedge clk); #1;
    tests++; if (dbg_prio !== 1'b0) begin fails++; $display("FAIL rst_pre_prio got %b exp 0", dbg_prio); end
    req1 = 0; req0 = 1; addr0 = 6'd8;
    @(negedge clk);
    tests++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL rst_gnt got %b exp 1", gnt0); end
    @(posedge clk); #1;
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    tests++; if (rvalid0 !== 1'b0 || rdata0 !== '0) begin fails++; $display("FAIL rst_rvalid_low got v=%b d=%h exp 0/0", rvalid0, rdata0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (dbg_state !== IDLE || dbg_prio !== 1'b0) begin fails++; $display("FAIL rst_release got st=%0d prio=%b exp 0/0", dbg_state, dbg_prio); end
    tests++; if ({rvalid0, rvalid1} !== 2'b00) begin fails++; $display("FAIL rst_no_rvalid got %b exp 00", {rvalid0, rvalid1}); end
  endtask

  task automatic test_random();
    logic          r_req [2];
    logic          r_lock[2];
    logic          r_we  [2];
    logic [AW-1:0] r_addr[2];
    logic [DW-1:0] r_wd  [2];
    logic          g_last[2];
    int            wait_cnt[2];
    logic          pend;
    logic [DW:0]   e;
    logic          g[2];
    do_reset();
    exp_q.delete();
    pend = 1'b0;
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 0; r_lock[p] = 0; r_we[p] = 0; r_addr[p] = '0; r_wd[p] = '0;
      g_last[p] = 0; wait_cnt[p] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (g_last[p]) r_req[p] = 0;
        if (!r_req[p] && $urandom_range(0, 3) != 0) begin
          r_req[p]  = 1;
          r_lock[p] = $urandom_range(0, 1) == 1;
          r_we[p]   = $urandom_range(0, 2) == 0;
          r_addr[p] = AW'($urandom_range(0, 63));
          r_wd[p]   = DW'($urandom);
          wait_cnt[p] = 0;
        end
      end
      req0 = r_req[0]; lock0 = r_lock[0]; we0 = r_we[0]; addr0 = r_addr[0]; wdata0 = r_wd[0];
      req1 = r_req[1]; lock1 = r_lock[1]; we1 = r_we[1]; addr1 = r_addr[1]; wdata1 = r_wd[1];
      @(negedge clk);
      g[0] = gnt0; g[1] = gnt1;
      tests++; if (gnt0 && gnt1) begin fails++; $display("FAIL rnd_excl cyc %0d got 11 exp at most one", c); end
      tests++;
      if (pend) begin
        e = exp_q.pop_front();
        if (e[DW] == 1'b0 && (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== e[DW-1:0])) begin
          fails++; $display("FAIL rnd_rd0 cyc %0d got v=%b%b d=%h exp 10/%h", c, rvalid0, rvalid1, rdata0, e[DW-1:0]);
        end else if (e[DW] == 1'b1 && (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== e[DW-1:0])) begin
          fails++; $display("FAIL rnd_rd1 cyc %0d got v=%b%b d=%h exp 01/%h", c, rvalid0, rvalid1, rdata1, e[DW-1:0]);
        end
      end else if ({rvalid0, rvalid1} !== 2'b00) begin
        fails++; $display("FAIL rnd_spurious cyc %0d got %b exp 00", c, {rvalid0, rvalid1});
      end
      pend = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (g[p] && !r_we[p]) begin
          exp_q.push_back({p[0], mem[r_addr[p]]});
          pend = 1'b1;
        end
        if (r_req[p]) begin
          wait_cnt[p]++;
          if (g[p]) begin
            tests++; if (wait_cnt[p] > MB + 1) begin fails++; $display("FAIL rnd_wait port %0d got %0d exp <= %0d", p, wait_cnt[p], MB + 1); end
          end
        end
        g_last[p] = g[p];
      end
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = DW'(i * 3);
    mem[8] = 16'h1234;
    test_reset();
    test_single_read();
    test_alternate();
    test_lock_burst();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 6, memory address width.
REQ-002 Parameter: DATA_WIDTH, default 16, memory data width.
REQ-003 Parameter: MAX_BURST, default 4, maximum consecutive grants to a locked port while the other port waits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req0 / req1  input  1  access request, port 0 (CPU) / port 1 (loader).
REQ-007 lock0 / lock1  input  1  port wants consecutive grants (burst).
REQ-008 we0 / we1  input  1  1 = write, 0 = read.
REQ-009 addr0 / addr1  input  ADDR_WIDTH  access address.
REQ-010 wdata0 / wdata1  input  DATA_WIDTH  write data.
REQ-011 gnt0 / gnt1  output  1  access accepted this cycle.
REQ-012 rvalid0 / rvalid1  output  1  read data valid for that port.
REQ-013 rdata0 / rdata1  output  DATA_WIDTH  read data.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  ADDR_WIDTH  memory address.
REQ-016 mem_data  output  DATA_WIDTH  memory write data.
REQ-017 mem_in  input  DATA_WIDTH  memory read data, valid one cycle after its address is presented.

Function
REQ-018 At most one grant per cycle; gnt0 and gnt1 are never both 1.
REQ-019 Grant is combinational from req, lock and registered state; the winner's we/addr/wdata drive mem_we/mem_addr/mem_data in the same cycle.
REQ-020 No grant: mem_we=0, mem_addr=0, mem_data=0.
REQ-021 A requester holds req, we, addr and wdata stable until it sees gnt; the access completes at the clock edge where gnt=1.
REQ-022 Granted read in cycle N: rvalidX=1 in cycle N+1 only; rdataX=mem_in in N+1. rdataX is 0 whenever rvalidX=0.
REQ-023 Granted write: committed at the edge ending cycle N; no rvalid is produced.
REQ-024 State machine: IDLE (no owner), OWN0, OWN1. Registered round-robin pointer prio (0/1) and burst counter bcnt (0..MAX_BURST).
REQ-025 IDLE: only one port requests -> that port is granted. Both request -> port prio is granted.
REQ-026 After any grant to port X: prio <= other port.
REQ-027 Grant to X with lockX=1 -> next state OWNX and bcnt <= 1. Grant with lockX=0 -> IDLE and bcnt <= 0.
REQ-028 OWNX, reqX=1, lockX=1, and (other port idle or bcnt<MAX_BURST) -> grant X, bcnt <= bcnt+1 (saturating at MAX_BURST), stay in OWNX.
REQ-029 OWNX with bcnt=MAX_BURST and other port requesting -> grant the other port. Next state follows REQ-027 for the newly granted port.
REQ-030 OWNX with reqX=0 or lockX=0 -> behave as IDLE for this cycle (REQ-025), including the resulting state update.
REQ-031 Back-to-back reads to alternating ports: each rvalid goes only to the port granted in the previous cycle, tracked by a registered port tag.

Reset
REQ-032 rst_n=0 forces immediately: state=IDLE, prio=0, bcnt=0, rvalid0=rvalid1=0, rdata0=rdata1=0, gnt0=gnt1=0, mem_we=0.
REQ-033 Reset during an outstanding read discards that read; no rvalid is issued after reset release.
REQ-034 Reset has priority over any simultaneous request.

Structure
REQ-035 Shared package mem_arb_pkg holds the state encoding (IDLE/OWN0/OWN1), the port index constants PORT_CPU=0 and PORT_LDR=1, and the default MAX_BURST.
REQ-036 bcnt is an instance of the codebase's register module, using inc and cl. No other sub-module.

Verification
REQ-037 Reset, then req0=1 read addr=8 with mem[8]=16'h1234 -> gnt0 in the same cycle; next cycle rvalid0=1, rdata0=16'h1234.
REQ-038 req0 and req1 asserted together from reset, no lock -> grants alternate 0,1,0,1 on consecutive cycles.
REQ-039 lock1=1 with continuous req1, and req0 held from cycle 0 -> port 1 receives 4 grants, then gnt0 on the 5th cycle.
REQ-040 Port 0 writes 16'hBEEF to addr 63, then port 1 reads addr 63 the next cycle -> rdata1=16'hBEEF, rvalid0 stays 0.
REQ-041 rst_n pulsed low in the cycle after a granted read -> rvalid stays 0; state=IDLE and prio=0 after release.
REQ-042 Random req/lock traffic for 10k cycles -> never both gnt high, every granted read produces exactly one rvalid, and no port waits more than MAX_BURST+1 cycles.
